// File: rtl/jtag_host_driver.sv
// jtag_host_driver: JTAG TAP host running DR/IR shifts and TAP resets on a divided TCK.
// TMS/TDI change at the start of each TCK low phase; TDO is captured on the rising TCK.
module jtag_host_driver #(
  parameter int TCK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         cmd_i,
  input  logic [6:0]         len_i,
  input  logic [MAX_LEN-1:0] data_i,
  input  logic               jtag_tdo,
  output logic               jtag_clk,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  output logic               busy_o,
  output logic               done_o,
  output logic [MAX_LEN-1:0] data_o
);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [7:0] CNT_TOP = 8'(TCK_DIV - 1);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
  typedef enum logic [2:0] {IDLE, TMS_SEQ, SHIFT, POST, DONE} state_t;
  state_t r_state, w_state_n;
  logic [7:0] r_cnt;
  logic r_tck, r_tms, r_tdi, r_zero;
  logic [1:0] r_cmd, w_cmd_n;
  logic [6:0] r_len, r_idx, w_idx_n, w_pre_last;
  logic [MAX_LEN-1:0] r_data, r_cap, r_dout;
  logic w_accept, w_zero_in, w_run, w_rise, w_fall, w_last, w_active_n, w_upd, w_tms_n, w_tdi_n;
  assign w_accept = r_state == IDLE && start_i;
  assign w_zero_in = &cmd_i || (!cmd_i[1] && len_i == 7'd0);
  assign w_run = r_state inside {TMS_SEQ, SHIFT, POST} && !r_zero;
  assign w_rise = w_run && !r_tck && r_cnt == 8'd0;
  assign w_fall = w_run && r_tck && r_cnt == 8'd0;
  assign w_cmd_n = w_accept ? cmd_i : r_cmd;
  assign w_pre_last = r_cmd[1] ? 7'd5 : r_cmd[0] ? 7'd3 : 7'd2;
  assign w_last = r_state == TMS_SEQ ? r_idx == w_pre_last :
                  r_state == SHIFT ? r_idx == r_len - 7'd1 : r_idx == 7'd1;
  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    case (r_state)
      IDLE: begin
        w_state_n = start_i ? TMS_SEQ : IDLE;
        w_idx_n = '0;
      end
      TMS_SEQ: w_state_n = r_zero ? DONE : (w_fall && w_last) ? (r_cmd[1] ? DONE : SHIFT) : TMS_SEQ;
      SHIFT: w_state_n = (w_fall && w_last) ? POST : SHIFT;
      POST: w_state_n = (w_fall && w_last) ? DONE : POST;
      default: w_state_n = IDLE;
    endcase
    if (w_fall) w_idx_n = w_last ? '0 : r_idx + 7'd1;
  end
  // Line values for the period about to begin, from the phase and the period index within it.
  assign w_active_n = w_state_n inside {TMS_SEQ, SHIFT, POST};
  assign w_tms_n = w_state_n == SHIFT ? w_idx_n == r_len - 7'd1 :
                   w_state_n == POST ? w_idx_n == 7'd0 :
                   w_cmd_n[1] ? w_idx_n != 7'd5 :
                   w_cmd_n[0] ? w_idx_n < 7'd2 : w_idx_n == 7'd0;
  assign w_tdi_n = w_state_n == SHIFT && r_data[w_idx_n[IW-1:0]];
  assign w_upd = (w_accept && !w_zero_in) || (w_fall && w_active_n);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_tck <= 1'b0;
      r_tms <= 1'b1;
      r_tdi <= 1'b0;
      r_zero <= 1'b0;
      r_cmd <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_data <= '0;
      r_cap <= '0;
      r_dout <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      if (w_upd) begin
        r_tms <= w_tms_n;
        r_tdi <= w_tdi_n;
      end
      if (w_accept) begin
        r_cmd <= cmd_i;
        r_len <= len_i > LEN_MAX ? LEN_MAX : len_i;
        r_data <= data_i;
        r_zero <= w_zero_in;
        r_cap <= '0;
        r_cnt <= CNT_TOP;
        r_tck <= 1'b0;
      end else if (w_run) begin
        r_cnt <= r_cnt == 8'd0 ? CNT_TOP : r_cnt - 8'd1;
        if (r_cnt == 8'd0) r_tck <= ~r_tck;
        if (w_rise && r_state == SHIFT) r_cap <= {jtag_tdo, r_cap[MAX_LEN-1:1]};
      end
      // TAP reset leaves the previous capture visible.
      if (w_state_n == DONE && r_cmd != 2'b10) r_dout <= r_zero ? '0 : r_cap >> (LEN_MAX - r_len);
    end
  end
  assign jtag_clk = r_tck;
  assign jtag_tms = r_tms;
  assign jtag_tdi = r_tdi;
  assign busy_o = r_state inside {TMS_SEQ, SHIFT, POST};
  assign done_o = r_state == DONE;
  assign data_o = r_dout;
endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver: randomized bench comparing jtag_host_driver against a per-TCK-period model.
module tb_jtag_host_driver;
  localparam int DIV = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] cmd = '0;
  logic [6:0] len = '0;
  logic [63:0] din = '0, dout, exp_dout = '0;
  logic tdo, tck, tms, tdi, busy, done, tdo_rnd = 1'b0;
  int mode = 0;
  int checks = 0, errors = 0;
  logic tms_q[$], tdi_q[$], tdo_q[$];
  jtag_host_driver #(.TCK_DIV(DIV), .MAX_LEN(64)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_i(cmd), .len_i(len), .data_i(din),
    .jtag_tdo(tdo), .jtag_clk(tck), .jtag_tms(tms), .jtag_tdi(tdi),
    .busy_o(busy), .done_o(done), .data_o(dout)
  );
  always #5 clk = ~clk;
  // mode 0: loopback, 1: random TDO per period, 2: TDO tied high
  assign tdo = (mode == 0) ? tdi : (mode == 2) ? 1'b1 : tdo_rnd;
  always @(negedge tck) tdo_rnd <= 1'($urandom);
  always @(posedge tck) begin
    tms_q.push_back(tms);
    tdi_q.push_back(tdi);
    tdo_q.push_back(tdo);
  end
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // Expected TMS/TDI per TCK period (bit i = period i) and period count.
  task automatic expect_seq(input logic [1:0] c, input int l, input logic [63:0] d,
                            output int n, output int pre, output logic [127:0] et, output logic [127:0] ed);
    et = '0;
    ed = '0;
    n = 0;
    pre = c[0] ? 4 : 3;
    if (c == 2'b10) begin
      et[4:0] = 5'b11111;
      n = 6;
    end else if (c != 2'b11 && l != 0) begin
      et[0] = 1'b1;
      if (c[0]) et[1] = 1'b1;
      for (int k = 0; k < l; k++) ed[pre+k] = d[k];
      et[pre+l-1] = 1'b1;
      et[pre+l] = 1'b1;
      n = pre + l + 2;
    end
  endtask
  task automatic run(input logic [1:0] c, input logic [6:0] l, input logic [63:0] d, input int m);
    int le, n, pre, cyc;
    logic [127:0] et, ed, at, ad;
    logic [63:0] edata;
    le = (l > 7'd64) ? 64 : int'(l);
    mode = m;
    expect_seq(c, le, d, n, pre, et, ed);
    tms_q.delete();
    tdi_q.delete();
    tdo_q.delete();
    cmd = c;
    len = l;
    din = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmd = 2'($urandom);
    len = 7'($urandom);
    din = {$urandom, $urandom};
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 2000) begin
      start = (cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("latency", cyc, n == 0 ? 1 : n * 2 * DIV);
    chk("busy_at_done", busy, 0);
    edata = '0;
    if (c == 2'b10) edata = exp_dout;
    else if (n != 0)
      for (int k = 0; k < le; k++)
        edata[k] = m == 0 ? d[k] : m == 2 ? 1'b1 : (pre + k < tdo_q.size() ? tdo_q[pre+k] : 1'b0);
    exp_dout = edata;
    chk("data_o", dout, exp_dout);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("tck_periods", tms_q.size(), n);
    at = '0;
    ad = '0;
    for (int i = 0; i < tms_q.size() && i < 128; i++) begin
      at[i] = tms_q[i];
      ad[i] = tdi_q[i];
    end
    chk("tms_seq", at, et);
    chk("tdi_seq", ad, ed);
  endtask
  initial begin
    int nd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", dout, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run(2'b00, 7'd8, 64'hA5, 0);
    run(2'b10, 7'd0, 64'h0, 1);
    run(2'b01, 7'd5, 64'h11, 2);
    run(2'b00, 7'd64, 64'hDEADBEEF_01234567, 0);
    run(2'b00, 7'd0, 64'hFFFF, 0);
    run(2'b11, 7'd10, 64'h3FF, 2);
    run(2'b00, 7'd100, {$urandom, $urandom}, 0);
    for (int i = 0; i < 20; i++)
      run(2'($urandom_range(0, 3)), 7'($urandom_range(0, 70)), {$urandom, $urandom}, $urandom_range(0, 2));
    mode = 0;
    cmd = 2'b00;
    len = 7'd32;
    din = {$urandom, $urandom};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("busy_mid_shift", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_dout = '0;
    rst = 1'b0;
    nd = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no_done_after_abort", nd, 0);
    run(2'b00, 7'd16, {$urandom, $urandom}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_host_driver.md
JTAG_HOST_DRIVER -- requirements
Module: jtag_host_driver

Interface
REQ-001 Parameter TCK_DIV, default 4, clk_i cycles per TCK half-period; legal range 2..255.
REQ-002 Parameter MAX_LEN, default 64, widest shift supported in bits; len_i is 7 bits wide.
REQ-003 clk_i  input  1  single system clock; every register in the block is clocked on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  single-cycle request to start a command; sampled only in IDLE.
REQ-006 cmd_i  input  2  command: 00 DR shift, 01 IR shift, 10 TAP reset, 11 reserved.
REQ-007 len_i  input  7  number of bits to shift, 0..64.
REQ-008 data_i  input  64  bits to shift out on TDI, LSB first.
REQ-009 jtag_tdo  input  1  TDO returned from the target TAP.
REQ-010 jtag_clk  output  1  generated TCK.
REQ-011 jtag_tms  output  1  TMS driven to the target.
REQ-012 jtag_tdi  output  1  TDI driven to the target.
REQ-013 busy_o  output  1  high from the cycle after an accepted start until done_o.
REQ-014 done_o  output  1  one-cycle pulse marking the end of a command.
REQ-015 data_o  output  64  captured TDO bits, right-aligned (first captured bit in bit 0); held until the next accepted command.

Function
REQ-016 TCK period: 2*TCK_DIV clk_i cycles; first half low, second half high; a half-period counter counts TCK_DIV-1 down to 0.
REQ-017 TMS and TDI update only in the clk_i cycle where jtag_clk goes 1->0 (the start of a low phase); TDO is sampled in the cycle where jtag_clk goes 0->1.
REQ-018 jtag_clk idles low; the counter is frozen while the block is IDLE.
REQ-019 States: IDLE, TMS_SEQ (preamble), SHIFT, POST (Exit1->Update->RTI), DONE.
REQ-020 Start is accepted when start_i=1 in IDLE: latch cmd_i, len_i and data_i, clear the capture register, assert busy_o on the next cycle.
REQ-021 DR preamble, starting from Run-Test/Idle: TMS sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR), one bit per TCK period.
REQ-022 IR preamble: TMS sequence 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
REQ-023 SHIFT: emit len TCK periods; TDI = data bit k in period k; TMS = 0 except in the final shift period, where TMS = 1 (Exit1).
REQ-024 Each sampled TDO bit enters the MSB of a 64-bit shift register, which shifts right; at DONE, data_o = capture >> (64 - len).
REQ-025 POST: TMS sequence 1,0 (Update, then RTI); TDI = 0.
REQ-026 TAP reset command: TMS = 1 for 5 TCK periods, then TMS = 0 for 1 period; data_o is unchanged.
REQ-027 DONE lasts 1 cycle: done_o = 1, busy_o drops in the same cycle, and the block returns to IDLE.
REQ-028 len_i = 0 on a shift command, or cmd_i = 11: no TCK is generated; DONE follows the accepted start by 1 cycle; data_o = 0.
REQ-029 len_i > 64 is clamped to 64.
REQ-030 start_i while busy is ignored with no side effect; start_i in the same cycle as DONE is also ignored.
REQ-031 data_i, len_i and cmd_i changes after acceptance have no effect on the command in progress.

Reset
REQ-032 While rst_i = 1: state IDLE, jtag_clk = 0, jtag_tms = 1, jtag_tdi = 0, busy_o = 0, done_o = 0, data_o = 0, counters = 0.
REQ-033 rst_i asserted mid-command aborts it at the next edge, with no done_o pulse; the target TAP state is then undefined, and software must issue a TAP reset command.

Verification
REQ-034 TCK_DIV=4, reset command -> 6 TCK periods (48 clk_i) with TMS 1,1,1,1,1,0; done_o pulses once; data_o unchanged.
REQ-035 DR shift, len=8, data_i=0xA5, loopback TDI->TDO -> 13 TCK periods (104 clk_i); TMS 1,0,0, then 0x7 followed by 1, then 1,0; TDI 1,0,1,0,0,1,0,1; data_o = 0xA5.
REQ-036 IR shift, len=5, data_i=0x11, tdo tied to 1 -> 11 TCK periods; TMS 1,1,0,0,0,0,0,0,1,1,0; data_o = 0x1F.
REQ-037 DR shift, len=64, data_i=0xDEADBEEF_01234567, loopback -> data_o equals data_i; start_i pulsed mid-shift is ignored.
REQ-038 len=0 DR command -> done_o 2 cycles after start_i, jtag_clk stays 0, data_o = 0.
REQ-039 rst_i asserted during SHIFT -> next cycle jtag_clk=0, jtag_tms=1, busy_o=0, no done_o; a new start then completes normally.
